// File: rtl/id_stage_pipe_pkg.sv
// Shared encodings and default widths for the instruction-decode stage.
package id_stage_pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_BEQ  = 2'd1,
    BR_BNE  = 2'd2,
    BR_JMP  = 2'd3
  } branch_t;

  typedef enum logic [3:0] {
    EXE_ADD = 4'd0,
    EXE_SUB = 4'd1,
    EXE_AND = 4'd2,
    EXE_OR  = 4'd3,
    EXE_XOR = 4'd4,
    EXE_SLL = 4'd5,
    EXE_SRL = 4'd6,
    EXE_SRA = 4'd7,
    EXE_SLT = 4'd8,
    EXE_NOP = 4'd15
  } exe_cmd_t;

endpackage

// File: rtl/reg_file_bypass.sv
// Register file with two combinational reads, one write port and write-to-read bypass.
module reg_file_bypass
  import id_stage_pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_N  = 32,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] mem [REG_N];

  // R0 reads as zero; a same-cycle write to the read index is returned directly.
  function automatic logic [DATA_W-1:0] read_port(logic [REG_AW-1:0] addr);
    if (addr == '0)
      return '0;
    else if (we && (waddr == addr))
      return wdata;
    else
      return mem[addr];
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_N; i++) mem[i] <= '0;
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1 = read_port(raddr1);
  assign rdata2 = read_port(raddr2);

endmodule

// File: rtl/id_stage_pipe.sv
// Instruction decode stage: operand read, immediate extension, hazard stall and ID/EX register.
module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_N  = 32,
  parameter int REG_AW = REG_AW_DEF,
  parameter int FWD_EN = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [31:0]       instr,
  input  logic              ctl_wb_en,
  input  logic              ctl_mem_read,
  input  logic              ctl_mem_write,
  input  logic              ctl_is_imm,
  input  logic              ctl_zero_ext,
  input  logic [1:0]        ctl_branch_type,
  input  logic [3:0]        ctl_exe_cmd,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_wb_en,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic              mem_wb_en,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic              flush,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_reg1,
  output logic [DATA_W-1:0] out_reg2,
  output logic [DATA_W-1:0] out_val2,
  output logic [REG_AW-1:0] out_dest,
  output logic [REG_AW-1:0] out_src1,
  output logic [REG_AW-1:0] out_src2,
  output logic              out_wb_en,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic [1:0]        out_branch_type,
  output logic [3:0]        out_exe_cmd
);

  logic [REG_AW-1:0] src1_p0, src2_p0, dest_p0;
  logic [DATA_W-1:0] reg1_p0, reg2_p0, imm_p0, val2_p0;
  logic              src2_used_p0, hazard_p0, load_p0, accept_p0;

  function automatic logic [DATA_W-1:0] ext_imm(logic [15:0] imm, logic zext);
    if (zext)
      return {{(DATA_W-16){1'b0}}, imm};
    else
      return {{(DATA_W-16){imm[15]}}, imm};
  endfunction

  function automatic logic src_hit(logic [REG_AW-1:0] src, logic used,
                                   logic [REG_AW-1:0] dst, logic en);
    return used && en && (src != '0) && (src == dst);
  endfunction

  assign src1_p0      = instr[21 +: REG_AW];
  assign src2_p0      = instr[16 +: REG_AW];
  assign dest_p0      = ctl_is_imm ? instr[16 +: REG_AW] : instr[11 +: REG_AW];
  assign src2_used_p0 = ~ctl_is_imm | ctl_mem_write;
  assign imm_p0       = ext_imm(instr[15:0], ctl_zero_ext);
  assign val2_p0      = ctl_is_imm ? imm_p0 : reg2_p0;

  reg_file_bypass #(
    .DATA_W (DATA_W),
    .REG_N  (REG_N),
    .REG_AW (REG_AW)
  ) u_rf (
    .clk    (clk),
    .rst    (rst),
    .raddr1 (src1_p0),
    .raddr2 (src2_p0),
    .rdata1 (reg1_p0),
    .rdata2 (reg2_p0),
    .we     (wb_we),
    .waddr  (wb_dest),
    .wdata  (wb_data)
  );

  // With forwarding only a load in EX cannot be bypassed; without it any pending writer stalls.
  always_comb begin
    hazard_p0 = 1'b0;
    if (in_valid) begin
      if (FWD_EN != 0)
        hazard_p0 = src_hit(src1_p0, 1'b1, ex_dest, ex_wb_en & ex_mem_read)
                  | src_hit(src2_p0, src2_used_p0, ex_dest, ex_wb_en & ex_mem_read);
      else
        hazard_p0 = src_hit(src1_p0, 1'b1, ex_dest, ex_wb_en)
                  | src_hit(src2_p0, src2_used_p0, ex_dest, ex_wb_en)
                  | src_hit(src1_p0, 1'b1, mem_dest, mem_wb_en)
                  | src_hit(src2_p0, src2_used_p0, mem_dest, mem_wb_en);
    end
  end

  assign load_p0   = ~out_valid | out_ready;
  assign in_ready  = load_p0 & ~hazard_p0 & ~flush;
  assign accept_p0 = in_valid & in_ready;

  // ---- p0 -> p1: ID/EX register ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid       <= 1'b0;
      out_pc          <= '0;
      out_reg1        <= '0;
      out_reg2        <= '0;
      out_val2        <= '0;
      out_dest        <= '0;
      out_src1        <= '0;
      out_src2        <= '0;
      out_wb_en       <= 1'b0;
      out_mem_read    <= 1'b0;
      out_mem_write   <= 1'b0;
      out_branch_type <= '0;
      out_exe_cmd     <= '0;
    end else begin
      if (flush)
        out_valid <= 1'b0;
      else if (load_p0)
        out_valid <= accept_p0;
      if (accept_p0) begin
        out_pc          <= pc_in;
        out_reg1        <= reg1_p0;
        out_reg2        <= reg2_p0;
        out_val2        <= val2_p0;
        out_dest        <= dest_p0;
        out_src1        <= src1_p0;
        out_src2        <= src2_p0;
        out_wb_en       <= ctl_wb_en;
        out_mem_read    <= ctl_mem_read;
        out_mem_write   <= ctl_mem_write;
        out_branch_type <= ctl_branch_type;
        out_exe_cmd     <= ctl_exe_cmd;
      end
    end
  end

endmodule
